// File: rtl/arb_pkg.sv
// Shared types and sizes for the 4-way round-robin / fixed-priority arbiter.
package arb_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned ID_W  = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

endpackage : arb_pkg

// File: rtl/round_robin_arbiter_4_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface round_robin_arbiter_4_if;
    import arb_pkg::*;

    logic [N_REQ-1:0] req;
    logic             mode;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             gnt_valid;

    modport master (
        output req,
        output mode,
        input  gnt,
        input  gnt_id,
        input  gnt_valid
    );

    modport slave (
        input  req,
        input  mode,
        output gnt,
        output gnt_id,
        output gnt_valid
    );

endinterface : round_robin_arbiter_4_if

// File: rtl/rr_pick4.sv
// Combinational winner selection: rotating search from ptr, or highest index in fixed mode.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    input  logic             mode,
    output logic [ID_W-1:0]  win_id,
    output logic             win_valid
);

    logic [ID_W-1:0] w_idx;

    // Scan so that the last hit written is the winner (nearest to ptr, or highest index).
    always_comb begin
        win_id    = '0;
        win_valid = |req;
        w_idx     = '0;
        if (mode) begin
            for (int i = 0; i < int'(N_REQ); i++) begin
                if (req[i]) begin
                    win_id = ID_W'(i);
                end
            end
        end else begin
            for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
                w_idx = ptr + ID_W'(k);
                if (req[w_idx]) begin
                    win_id = w_idx;
                end
            end
        end
    end

endmodule : rr_pick4

// File: rtl/round_robin_arbiter_4.sv
// 4-requester arbiter: IDLE/GRANT FSM, rotating pointer, hold limit, registered grant outputs.
module round_robin_arbiter_4
    import arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned HOLD_W   = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    round_robin_arbiter_4_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [N_REQ-1:0] r_gnt;
    logic [N_REQ-1:0] w_gnt_nxt;
    logic [ID_W-1:0]  r_gnt_id;
    logic [ID_W-1:0]  w_gnt_id_nxt;
    logic             r_gnt_valid;
    logic             w_gnt_valid_nxt;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;

    logic [ID_W-1:0]  w_win_id;
    logic             w_win_valid;
    logic             w_hold_limit;
    logic             w_release;

    rr_pick4 u_pick (
        .req       (bus.req),
        .ptr       (r_ptr),
        .mode      (bus.mode),
        .win_id    (w_win_id),
        .win_valid (w_win_valid)
    );

    // Owner is released when it drops its request or has used up its hold budget.
    assign w_hold_limit = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD - 1));
    assign w_release    = !bus.req[r_gnt_id] || w_hold_limit;

    // Next-state and next-output decode; mode only matters on the IDLE->GRANT decision.
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_gnt_id_nxt    = r_gnt_id;
        w_gnt_valid_nxt = r_gnt_valid;
        w_ptr_nxt       = r_ptr;
        w_hold_nxt      = r_hold;
        case (r_state)
            IDLE: begin
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
                if (w_win_valid) begin
                    w_state_nxt     = GRANT;
                    w_gnt_nxt       = N_REQ'(1) << w_win_id;
                    w_gnt_id_nxt    = w_win_id;
                    w_gnt_valid_nxt = 1'b1;
                    w_hold_nxt      = '0;
                    if (!bus.mode) begin
                        w_ptr_nxt = w_win_id + ID_W'(1);
                    end
                end
            end
            GRANT: begin
                if (w_release) begin
                    w_state_nxt     = IDLE;
                    w_gnt_nxt       = '0;
                    w_gnt_valid_nxt = 1'b0;
                end else begin
                    w_hold_nxt = r_hold + HOLD_W'(1);
                end
            end
            default: begin
                w_state_nxt     = IDLE;
                w_gnt_nxt       = '0;
                w_gnt_valid_nxt = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_gnt       <= '0;
            r_gnt_id    <= '0;
            r_gnt_valid <= 1'b0;
            r_ptr       <= '0;
            r_hold      <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_id    <= w_gnt_id_nxt;
            r_gnt_valid <= w_gnt_valid_nxt;
            r_ptr       <= w_ptr_nxt;
            r_hold      <= w_hold_nxt;
        end
    end

    assign bus.gnt       = r_gnt;
    assign bus.gnt_id    = r_gnt_id;
    assign bus.gnt_valid = r_gnt_valid;

endmodule : round_robin_arbiter_4

// File: doc/round_robin_arbiter_4.md
ROUND_ROBIN_ARBITER_4 -- requirements
Module: round_robin_arbiter_4

Interface
REQ-001 The block SHALL have one clock and one reset: reset is synchronous and active-low.
REQ-002 Parameter MAX_HOLD, default 8: max consecutive grant cycles per owner. Value 0 SHALL disable the limit.
REQ-003 Parameter HOLD_W, default 4: hold counter width. MAX_HOLD SHALL fit in HOLD_W bits.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port req  input  4  request per requester; bit i = requester i.
REQ-007 Port mode  input  1  0 = round-robin, 1 = fixed priority (bit 3 highest, bit 0 lowest).
REQ-008 Port gnt  output  4  one-hot grant, registered.
REQ-009 Port gnt_id  output  2  binary index of the granted requester, registered.
REQ-010 Port gnt_valid  output  1  high when any grant is active, registered; equals |gnt.

Function
REQ-011 The FSM SHALL have two states: IDLE and GRANT.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE with gnt=0, gnt_valid=0, and gnt_id holding its last value.
REQ-013 In IDLE with req!=0 sampled at edge N, the block SHALL enter GRANT with gnt/gnt_id/gnt_valid valid after edge N (1-cycle latency).
REQ-014 Round-robin winner: the first set bit searching ptr, ptr+1, ... modulo 4, where ptr is the highest-priority index.
REQ-015 Fixed-priority winner: the highest-index set bit; ptr SHALL NOT change in fixed mode.
REQ-016 On a round-robin grant to index i, ptr SHALL become (i+1) mod 4, so 3 wraps to 0.
REQ-017 mode SHALL be sampled only on the IDLE->GRANT edge; changes during GRANT SHALL have no effect on the current grant.
REQ-018 In GRANT, the grant SHALL be held while req[gnt_id] remains 1; requests from other requesters SHALL be ignored.
REQ-019 The grant SHALL be released on the edge that samples req[gnt_id]=0: next state IDLE, gnt=0, gnt_valid=0.
REQ-020 Hold counter: cleared on grant, incremented each GRANT cycle.
REQ-021 Forced release: if MAX_HOLD!=0 and the counter reaches MAX_HOLD-1 while req[gnt_id]=1, the block SHALL release on that edge, so gnt is high for exactly MAX_HOLD cycles.
REQ-022 After any release, at least one gnt=0 cycle SHALL occur before the next grant (no back-to-back handoff).
REQ-023 A forced-release owner that still requests SHALL be arbitrated normally; in round-robin it has lowest priority for the next pick.
REQ-024 gnt SHALL never have more than one bit set in any cycle.

Reset
REQ-025 With rst_n=0 at a clock edge: state=IDLE, gnt=4'b0000, gnt_id=2'b00, gnt_valid=0, ptr=0, hold counter=0.
REQ-026 Reset asserted during GRANT SHALL drop the grant on that same edge; req during reset SHALL be ignored.
REQ-027 The first arbitration after reset release SHALL use ptr=0.

Structure
REQ-028 Shared package arb_pkg SHALL hold: the state enum (IDLE, GRANT), N_REQ=4, and ID_W=2.
REQ-029 Sub-module rr_pick4 (combinational) SHALL provide the winner: inputs req, ptr, mode; outputs win_id and win_valid.
REQ-030 Sequential logic (FSM, ptr, counter, output registers) SHALL reside in round_robin_arbiter_4.

Verification
REQ-031 Reset then req=0000 for 5 cycles -> gnt=0000, gnt_valid=0, gnt_id=00 throughout.
REQ-032 mode=0, req=1111 held, each owner drops its req 2 cycles after being granted -> grant order 0,1,2,3,0, with one idle cycle between grants.
REQ-033 mode=1, req=0101 -> gnt=0100, gnt_id=10. Then drop req[2] -> gnt=0000 for 1 cycle, then gnt=0001.
REQ-034 MAX_HOLD=8, req=0010 held for 20 cycles -> gnt=0010 for exactly 8 cycles, 1 cycle of 0000, then re-granted.
REQ-035 After a grant to 3 (ptr=0), req=1001 -> grant 0 (wrap check). Then switch mode mid-GRANT -> current grant unchanged.
REQ-036 rst_n=0 for 1 cycle during GRANT with req=1111 -> next cycle gnt=0000, ptr=0. The next grant goes to requester 0.
